// File: rtl/dbus_bridge_pkg.sv
// Shared types and constants for the data-bus bridge and its helpers.
// The state encoding is fixed at 2 bits so future bus bridges can share it.
package dbus_bridge_pkg;

    typedef enum logic [1:0] {
        DBUS_IDLE = 2'd0,
        DBUS_ADDR = 2'd1,
        DBUS_DATA = 2'd2,
        DBUS_DONE = 2'd3
    } dbus_state_e;

    localparam int          DBUS_TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;
    localparam logic        WRITE_DISABLE        = 1'b0;

endpackage

// File: rtl/dbus_bridge_watchdog.sv
// Cycle watchdog for bus bridges: counts enabled cycles and flags expiry
// on the cycle that would bring the count up to TIMEOUT (0 = never expires).
module dbus_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic i_clk,
    input  logic i_rs,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [TO_W-1:0] LP_LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] r_count;
    logic [TO_W-1:0] w_countNext;

    assign w_countNext = r_count + TO_W'(1);
    // Expiry looks at the post-increment value so the bus phase lasts at most TIMEOUT cycles.
    assign o_expire    = (TIMEOUT != 0) && i_enable && (w_countNext == LP_LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_rs || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_countNext;
        end
    end

endmodule

// File: rtl/dbus_bridge.sv
// Bridges the LSU single-cycle data request onto a valid/ready request plus
// response bus, stalling the pipeline while the access is outstanding.
module dbus_bridge
    import dbus_bridge_pkg::*;
#(
    parameter int TIMEOUT = DBUS_TIMEOUT_DEFAULT,
    parameter int TO_W    = 8
) (
    input  logic        clk_i,
    input  logic        rs_i,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_a_i,
    input  logic [31:0] mem_wd_i,
    input  logic        hold_i,
    output logic [31:0] mem_rd_o,
    output logic        stall_req_o,
    output logic        bus_err_o,
    output logic        bus_req_valid_o,
    input  logic        bus_req_ready_i,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_a_o,
    output logic [31:0] bus_wd_o,
    input  logic        bus_rsp_valid_i,
    input  logic        bus_rsp_err_i,
    input  logic [31:0] bus_rdata_i
);

    dbus_state_e r_state;
    logic        r_reqValid;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic w_start;
    logic w_busPhase;
    logic w_expire;

    assign w_start    = (r_state == DBUS_IDLE) && mem_ce_i;
    assign w_busPhase = (r_state == DBUS_ADDR) || (r_state == DBUS_DATA);

    // The stall rises in the request cycle itself so the LSU freezes immediately.
    assign stall_req_o     = w_start || w_busPhase;
    assign bus_req_valid_o = r_reqValid;
    assign bus_we_o        = r_we;
    assign bus_sel_o       = r_sel;
    assign bus_a_o         = r_addr;
    assign bus_wd_o        = r_wdata;
    assign mem_rd_o        = r_rdata;
    assign bus_err_o       = r_err;

    dbus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .i_clk    (clk_i),
        .i_rs     (rs_i),
        .i_clear  (w_start),
        .i_enable (w_busPhase),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rs_i) begin
            r_state    <= DBUS_IDLE;
            r_reqValid <= 1'b0;
            r_we       <= WRITE_DISABLE;
            r_sel      <= 4'h0;
            r_addr     <= ZERO_WORD;
            r_wdata    <= ZERO_WORD;
            r_rdata    <= ZERO_WORD;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                DBUS_IDLE: begin
                    if (mem_ce_i) begin
                        r_we       <= mem_we_i;
                        r_sel      <= mem_sel_i;
                        r_addr     <= mem_a_i;
                        r_wdata    <= mem_wd_i;
                        r_reqValid <= 1'b1;
                        r_state    <= DBUS_ADDR;
                    end
                end
                // Responses seen here precede acceptance and are deliberately ignored.
                DBUS_ADDR: begin
                    if (w_expire) begin
                        r_reqValid <= 1'b0;
                        r_err      <= 1'b1;
                        r_rdata    <= ZERO_WORD;
                        r_state    <= DBUS_DONE;
                    end else if (bus_req_ready_i) begin
                        r_reqValid <= 1'b0;
                        r_state    <= DBUS_DATA;
                    end
                end
                DBUS_DATA: begin
                    if (bus_rsp_valid_i) begin
                        if (!r_we) begin
                            r_rdata <= bus_rdata_i;
                        end
                        r_err   <= bus_rsp_err_i;
                        r_state <= DBUS_DONE;
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_rdata <= ZERO_WORD;
                        r_state <= DBUS_DONE;
                    end
                end
                DBUS_DONE: begin
                    if (!hold_i) begin
                        r_state <= DBUS_IDLE;
                    end
                end
                default: r_state <= DBUS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_bridge.sv
// Self-checking bench for dbus_bridge: directed table, reset-in-flight sequence,
// then random transactions scored against a transaction-level timing model.
module tb_dbus_bridge;

    localparam int TO = 8;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        rspErr;
        int          readyDelay;
        int          rspDelay;
        int          holdCycles;
        int          expStall;
        logic        expErr;
        logic [31:0] expRd;
        int          expHs;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rs_i;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_a_i;
    logic [31:0] mem_wd_i;
    logic        hold_i;
    logic [31:0] mem_rd_o;
    logic        stall_req_o;
    logic        bus_err_o;
    logic        bus_req_valid_o;
    logic        bus_req_ready_i;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_a_o;
    logic [31:0] bus_wd_o;
    logic        bus_rsp_valid_i;
    logic        bus_rsp_err_i;
    logic [31:0] bus_rdata_i;

    int          total = 0;
    int          bad = 0;
    int          hsCount = 0;
    logic [31:0] modelRd;
    txn_t        dirVec[7];
    txn_t        tx;

    always #5 clk_i = ~clk_i;

    dbus_bridge #(
        .TIMEOUT (TO),
        .TO_W    (8)
    ) dut (
        .clk_i           (clk_i),
        .rs_i            (rs_i),
        .mem_ce_i        (mem_ce_i),
        .mem_we_i        (mem_we_i),
        .mem_sel_i       (mem_sel_i),
        .mem_a_i         (mem_a_i),
        .mem_wd_i        (mem_wd_i),
        .hold_i          (hold_i),
        .mem_rd_o        (mem_rd_o),
        .stall_req_o     (stall_req_o),
        .bus_err_o       (bus_err_o),
        .bus_req_valid_o (bus_req_valid_o),
        .bus_req_ready_i (bus_req_ready_i),
        .bus_we_o        (bus_we_o),
        .bus_sel_o       (bus_sel_o),
        .bus_a_o         (bus_a_o),
        .bus_wd_o        (bus_wd_o),
        .bus_rsp_valid_i (bus_rsp_valid_i),
        .bus_rsp_err_i   (bus_rsp_err_i),
        .bus_rdata_i     (bus_rdata_i)
    );

    // Counts accepted request handshakes as the slave would see them.
    always @(posedge clk_i) begin
        if (!rs_i && bus_req_valid_o && bus_req_ready_i) hsCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkCleared(input string tag);
        #1;
        checkOutput({tag, "_valid"}, {31'd0, bus_req_valid_o}, 32'd0);
        checkOutput({tag, "_ctrl"}, {27'd0, bus_we_o, bus_sel_o}, 32'd0);
        checkOutput({tag, "_addr"}, bus_a_o, 32'd0);
        checkOutput({tag, "_wdata"}, bus_wd_o, 32'd0);
        checkOutput({tag, "_rd"}, mem_rd_o, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, bus_err_o}, 32'd0);
        checkOutput({tag, "_stall"}, {31'd0, stall_req_o}, 32'd0);
    endtask

    function automatic txn_t mkTxn(input logic we, input logic [3:0] sel, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rdata, input logic rspErr,
                                   input int rdy, input int rsp, input int hold, input int expStall,
                                   input logic expErr, input logic [31:0] expRd, input int expHs);
        txn_t t;
        t.we = we; t.sel = sel; t.a = a; t.wd = wd; t.rdata = rdata; t.rspErr = rspErr;
        t.readyDelay = rdy; t.rspDelay = rsp; t.holdCycles = hold;
        t.expStall = expStall; t.expErr = expErr; t.expRd = expRd; t.expHs = expHs;
        return t;
    endfunction

    // Transaction-level model: bus time is the sum of the two phases, capped at TO.
    function automatic txn_t modelTxn(input txn_t t, input logic [31:0] prevRd);
        txn_t r;
        int addrCycles;
        int dataCycles;
        r = t;
        addrCycles = t.readyDelay + 1;
        dataCycles = t.rspDelay + 1;
        if (addrCycles >= TO) begin
            r.expStall = 1 + TO; r.expErr = 1'b1; r.expRd = 32'h0; r.expHs = 0;
        end else if (addrCycles + dataCycles > TO) begin
            r.expStall = 1 + TO; r.expErr = 1'b1; r.expRd = 32'h0; r.expHs = 1;
        end else begin
            r.expStall = 1 + addrCycles + dataCycles;
            r.expErr   = t.rspErr;
            r.expRd    = t.we ? prevRd : t.rdata;
            r.expHs    = 1;
        end
        return r;
    endfunction

    task automatic applyStimulus(input txn_t t);
        int addrCycles;
        int busCycles;
        int validCycles;
        int stallCnt;
        int hsStart;
        bit done;
        addrCycles  = t.readyDelay + 1;
        busCycles   = t.expStall - 1;
        validCycles = (addrCycles < TO) ? addrCycles : TO;
        @(negedge clk_i);
        mem_ce_i = 1'b1; mem_we_i = t.we; mem_sel_i = t.sel; mem_a_i = t.a; mem_wd_i = t.wd;
        hold_i = 1'b0; bus_req_ready_i = 1'b0;
        bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0; bus_rdata_i = 32'h0;
        hsStart = hsCount;
        #1;
        checkOutput("stall_on_request", {31'd0, stall_req_o}, 32'd1);
        stallCnt = 1;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk_i);
            checkOutput("req_valid", {31'd0, bus_req_valid_o}, (k <= validCycles) ? 32'd1 : 32'd0);
            if (k <= validCycles) begin
                checkOutput("req_ctrl", {27'd0, bus_we_o, bus_sel_o}, {27'd0, t.we, t.sel});
                checkOutput("req_addr", bus_a_o, t.a);
                checkOutput("req_wdata", bus_wd_o, t.wd);
            end
            bus_req_ready_i = (k == addrCycles);
            if (k == addrCycles + t.rspDelay + 1) begin
                bus_rsp_valid_i = 1'b1; bus_rsp_err_i = t.rspErr; bus_rdata_i = t.rdata;
            end else if (k <= addrCycles || k > busCycles) begin
                bus_rsp_valid_i = 1'($urandom_range(0, 1)); bus_rsp_err_i = 1'b1; bus_rdata_i = $urandom;
            end else begin
                bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0; bus_rdata_i = 32'h0;
            end
            #1;
            if (stall_req_o) stallCnt++;
            else done = 1'b1;
        end
        if (!done) begin
            total++; bad++;
            $display("[TB] FAIL done_wait: stall still high after 40 cycles, required release");
        end
        checkOutput("stall_cycles", stallCnt, t.expStall);
        checkOutput("rd_data", mem_rd_o, t.expRd);
        checkOutput("bus_err", {31'd0, bus_err_o}, {31'd0, t.expErr});
        mem_ce_i = 1'b0;
        bus_req_ready_i = 1'b0;
        hold_i = (t.holdCycles > 0);
        for (int h = 1; h <= t.holdCycles; h++) begin
            @(negedge clk_i);
            bus_rsp_valid_i = 1'b1; bus_rsp_err_i = ~t.expErr; bus_rdata_i = $urandom;
            hold_i = (h < t.holdCycles);
            #1;
            checkOutput("hold_stall", {31'd0, stall_req_o}, 32'd0);
            checkOutput("hold_rd", mem_rd_o, t.expRd);
            checkOutput("hold_err", {31'd0, bus_err_o}, {31'd0, t.expErr});
        end
        checkOutput("handshakes", hsCount - hsStart, t.expHs);
    endtask

    initial begin
        dirVec[0] = mkTxn(1'b0, 4'hF,    32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 0,  0, 0, 3, 1'b0, 32'hDEADBEEF, 1);
        dirVec[1] = mkTxn(1'b1, 4'b0011, 32'h204, 32'h12341234, 32'hAAAA5555, 1'b0, 3,  2, 0, 8, 1'b0, 32'hDEADBEEF, 1);
        dirVec[2] = mkTxn(1'b0, 4'hF,    32'h300, 32'h0,        32'h0BADF00D, 1'b1, 1,  1, 0, 5, 1'b1, 32'h0BADF00D, 1);
        dirVec[3] = mkTxn(1'b0, 4'hF,    32'h040, 32'h0,        32'hCAFEF00D, 1'b0, 0,  0, 3, 3, 1'b0, 32'hCAFEF00D, 1);
        dirVec[4] = mkTxn(1'b0, 4'hF,    32'h800, 32'h0,        32'h55555555, 1'b0, 99, 0, 1, 9, 1'b1, 32'h0,        0);
        dirVec[5] = mkTxn(1'b1, 4'hC,    32'h900, 32'hA5A5A5A5, 32'h77777777, 1'b0, 0,  9, 0, 9, 1'b1, 32'h0,        1);
        dirVec[6] = mkTxn(1'b0, 4'hF,    32'hA00, 32'h0,        32'h13572468, 1'b0, 1,  5, 0, 9, 1'b0, 32'h13572468, 1);

        rs_i = 1'b1; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0; mem_a_i = 32'h0; mem_wd_i = 32'h0;
        hold_i = 1'b0; bus_req_ready_i = 1'b0; bus_rsp_valid_i = 1'b0; bus_rsp_err_i = 1'b0; bus_rdata_i = 32'h0;
        repeat (3) @(negedge clk_i);
        checkCleared("reset");
        rs_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(dirVec[i]);
        end

        // Reset while waiting for a response in the data phase.
        @(negedge clk_i);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_a_i = 32'h500;
        @(negedge clk_i);
        bus_req_ready_i = 1'b1;
        @(negedge clk_i);
        bus_req_ready_i = 1'b0;
        #1;
        checkOutput("midreset_data_valid", {31'd0, bus_req_valid_o}, 32'd0);
        checkOutput("midreset_data_stall", {31'd0, stall_req_o}, 32'd1);
        @(negedge clk_i);
        rs_i = 1'b1; mem_ce_i = 1'b0;
        @(negedge clk_i);
        checkCleared("midreset");
        rs_i = 1'b0;

        tx = modelTxn(mkTxn(1'b0, 4'h3, 32'h0C0, 32'h0, 32'h600DCAFE, 1'b0, 0, 1, 0, 0, 1'b0, 32'h0, 0), 32'h0);
        applyStimulus(tx);
        modelRd = tx.expRd;

        for (int n = 0; n < 40; n++) begin
            tx.we         = 1'($urandom_range(0, 1));
            tx.sel        = 4'($urandom);
            tx.a          = $urandom;
            tx.wd         = $urandom;
            tx.rdata      = $urandom;
            tx.rspErr     = ($urandom_range(0, 3) == 0);
            tx.readyDelay = int'($urandom_range(0, 5));
            tx.rspDelay   = int'($urandom_range(0, 5));
            tx.holdCycles = int'($urandom_range(0, 2));
            tx = modelTxn(tx, modelRd);
            applyStimulus(tx);
            modelRd = tx.expRd;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
